// File: rtl/t05_mem_pkg.sv
// rtl/t05_mem_pkg.sv - shared types, funct3 codes and access-size helpers for the data-memory handler
package t05_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unused encodings (011, 110, 111) fall through to a word access.
  function automatic size_e size_decode(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      F3_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_B:    return 4'b0001 << lo;
      SZ_H:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_rep(input size_e sz, input logic [31:0] d);
    case (sz)
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/t05_data_mem_handler_if.sv
// rtl/t05_data_mem_handler_if.sv - data-memory bus between the handler (master) and the arbiter (slave)
interface t05_data_mem_handler_if;

  logic        req;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, adr, sel, wdata, input ack, rdata);
  modport slave  (input req, we, adr, sel, wdata, output ack, rdata);

endinterface

// File: rtl/t05_load_align.sv
// rtl/t05_load_align.sv - picks the addressed lane of a read word and sign/zero-extends it
module t05_load_align
  import t05_mem_pkg::*;
(
  input  logic [31:0] bus_rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = bus_rdata >> {addr, 3'b000};

  always_comb begin
    data = bus_rdata;
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {24'b0, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {16'b0, shifted[15:0]};
      default: data = bus_rdata;
    endcase
  end

endmodule

// File: rtl/t05_data_mem_handler.sv
// rtl/t05_data_mem_handler.sv - executes load/store requests as handshaked bus transactions
// while freezing the core; aborts with bus_err when the bus does not answer within TIMEOUT cycles.
module t05_data_mem_handler
  import t05_mem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [2:0]             funct3,
  input  logic [31:0]            read_address,
  input  logic [31:0]            write_address,
  input  logic [31:0]            write_data,
  t05_data_mem_handler_if.master bus,
  output logic [31:0]            load_data,
  output logic                   freeze,
  output logic                   misaligned,
  output logic                   bus_err
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         lo_q;
  logic [2:0]         f3_q;
  logic               access;
  logic               mis;
  logic [31:0]        addr;
  size_e              sz;
  logic [31:0]        aligned_data;

  // A store wins when both request lines are up.
  assign access = mem_read | mem_write;
  assign addr   = mem_write ? write_address : read_address;
  assign sz     = size_decode(funct3);
  assign mis    = ((sz == SZ_W) && (addr[1:0] != 2'b00)) || ((sz == SZ_H) && addr[0]);
  assign freeze = ((state == ST_IDLE) && access && !mis) || (state == ST_REQ);

  t05_load_align u_align (
    .bus_rdata (bus.rdata),
    .addr      (lo_q),
    .funct3    (f3_q),
    .data      (aligned_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lo_q       <= 2'b00;
      f3_q       <= 3'b000;
      bus.req    <= 1'b0;
      bus.we     <= 1'b0;
      bus.adr    <= '0;
      bus.sel    <= '0;
      bus.wdata  <= '0;
      load_data  <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (access) begin
            if (mis) begin
              misaligned <= 1'b1;
            end else begin
              bus.req   <= 1'b1;
              bus.we    <= mem_write;
              bus.adr   <= {addr[31:2], 2'b00};
              bus.sel   <= lane_sel(sz, addr[1:0]);
              bus.wdata <= store_rep(sz, write_data);
              lo_q      <= addr[1:0];
              f3_q      <= funct3;
              cnt       <= '0;
              state     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (bus.ack) begin
            bus.req <= 1'b0;
            if (!bus.we) load_data <= aligned_data;
            state <= ST_DONE;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            bus.req <= 1'b0;
            bus_err <= 1'b1;
            if (!bus.we) load_data <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // Requests seen here belong to the instruction that is retiring.
        ST_DONE: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t05_data_mem_handler.sv
// tb/tb_t05_data_mem_handler.sv - self-checking bench for t05_data_mem_handler
module tb_t05_data_mem_handler;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] read_address, write_address, write_data;
  logic [31:0] load_data;
  logic        freeze, misaligned, bus_err;

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_load = 32'h0;

  t05_data_mem_handler_if bus ();

  t05_data_mem_handler #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .funct3        (funct3),
    .read_address  (read_address),
    .write_address (write_address),
    .write_data    (write_data),
    .bus           (bus),
    .load_data     (load_data),
    .freeze        (freeze),
    .misaligned    (misaligned),
    .bus_err       (bus_err)
  );

  always #5 clk = ~clk;

  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input int lo, input logic [2:0] f3);
    logic [31:0] v;
    v = rd >> (8 * lo);
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v > 32'd127)   v = v + 32'hFFFFFF00; end
      3'd4: v = v & 32'hFF;
      3'd1: begin v = v & 32'hFFFF; if (v > 32'd32767) v = v + 32'hFFFF0000; end
      3'd5: v = v & 32'hFFFF;
      default: v = rd;
    endcase
    return v;
  endfunction

  // ack_at: REQ cycle (1-based) carrying bus_ack; 0 means the bus never answers.
  task automatic do_access(input bit wr, input bit both, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int ack_at, input string nm);
    int          sz, lo, n_req, exp_req, fr;
    logic [31:0] e_sel, e_wd, e_adr;
    sz      = size_of(f3);
    lo      = int'(a[1:0]);
    e_adr   = a & 32'hFFFFFFFC;
    e_sel   = (sz == 1) ? (32'd1 << lo) : (sz == 2) ? ((lo >= 2) ? 32'd12 : 32'd3) : 32'd15;
    e_wd    = (sz == 1) ? (wd & 32'hFF) * 32'h01010101 : (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    exp_req = (ack_at == 0) ? TIMEOUT + 1 : ack_at;
    mem_read  = !wr || both;
    mem_write = wr;
    funct3    = f3;
    if (wr) begin write_address = a; read_address = $urandom; end
    else    begin read_address = a;  write_address = $urandom; end
    write_data = wd;
    bus.ack    = 1'b0;
    bus.rdata  = $urandom;
    #1;
    fr = freeze ? 1 : 0;
    n_req = 0;
    for (int c = 1; c <= TIMEOUT + 2; c++) begin
      @(posedge clk); #1;
      if (!bus.req) break;
      n_req++;
      if (freeze) fr++;
      bus.ack   = (c == ack_at);
      bus.rdata = (c == ack_at) ? rd : $urandom;
      #1;
      n_total++;
      if (bus.adr !== e_adr || bus.sel !== e_sel[3:0] || bus.we !== wr || (wr && bus.wdata !== e_wd))
        $display("FAIL %s bus: adr=%h sel=%b we=%b wdata=%h expected adr=%h sel=%b we=%b wdata=%h",
                 nm, bus.adr, bus.sel, bus.we, bus.wdata, e_adr, e_sel[3:0], wr, e_wd);
      else n_pass++;
    end
    bus.ack = 1'b0;
    if (!wr) exp_load = (ack_at == 0) ? 32'h0 : ref_load(rd, lo, f3);
    #1;
    n_total++;
    if (n_req !== exp_req || fr !== exp_req + 1)
      $display("FAIL %s latency: req_cycles=%0d freeze_cycles=%0d expected %0d/%0d", nm, n_req, fr, exp_req, exp_req + 1);
    else n_pass++;
    n_total++;
    if (freeze !== 1'b0 || bus.req !== 1'b0 || bus_err !== (ack_at == 0) || load_data !== exp_load)
      $display("FAIL %s done: freeze=%b req=%b err=%b load=%h expected 0/0/%b/%h",
               nm, freeze, bus.req, bus_err, load_data, (ack_at == 0), exp_load);
    else n_pass++;
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
    n_total++;
    if (bus.req !== 1'b0 || bus_err !== 1'b0 || freeze !== 1'b0 || load_data !== exp_load)
      $display("FAIL %s idle: req=%b err=%b freeze=%b load=%h expected 0/0/0/%h",
               nm, bus.req, bus_err, freeze, load_data, exp_load);
    else n_pass++;
  endtask

  task automatic do_misaligned(input logic [2:0] f3, input logic [31:0] a, input string nm);
    mem_read = 1'b1; mem_write = 1'b0; funct3 = f3; read_address = a;
    #1;
    n_total++;
    if (freeze !== 1'b0) $display("FAIL %s freeze: got %b expected 0", nm, freeze); else n_pass++;
    @(posedge clk); #1;
    mem_read = 1'b0;
    #1;
    n_total++;
    if (misaligned !== 1'b1 || bus.req !== 1'b0)
      $display("FAIL %s pulse: misaligned=%b req=%b expected 1/0", nm, misaligned, bus.req);
    else n_pass++;
    @(posedge clk); #2;
    n_total++;
    if (misaligned !== 1'b0 || bus.req !== 1'b0 || load_data !== exp_load)
      $display("FAIL %s after: misaligned=%b req=%b load=%h expected 0/0/%h", nm, misaligned, bus.req, load_data, exp_load);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    read_address = '0; write_address = '0; write_data = '0; bus.ack = 1'b0; bus.rdata = '0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; #1;
    n_total++;
    if (bus.req !== 1'b0 || bus.we !== 1'b0 || bus.adr !== 32'h0 || bus.sel !== 4'h0 || bus.wdata !== 32'h0 ||
        load_data !== 32'h0 || misaligned !== 1'b0 || bus_err !== 1'b0 || freeze !== 1'b0)
      $display("FAIL reset: req=%b we=%b adr=%h sel=%b wdata=%h load=%h mis=%b err=%b freeze=%b expected all 0",
               bus.req, bus.we, bus.adr, bus.sel, bus.wdata, load_data, misaligned, bus_err, freeze);
    else n_pass++;
  endtask

  task automatic test_directed();
    do_access(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, "lw_0x100");
    n_total++;
    if (load_data !== 32'hDEADBEEF) $display("FAIL lw_value: got %h expected deadbeef", load_data); else n_pass++;
    do_access(1'b0, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80000000, 1, "lb_0x203");
    n_total++;
    if (load_data !== 32'hFFFFFF80) $display("FAIL lb_value: got %h expected ffffff80", load_data); else n_pass++;
    do_access(1'b0, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80000000, 2, "lbu_0x203");
    n_total++;
    if (load_data !== 32'h00000080) $display("FAIL lbu_value: got %h expected 00000080", load_data); else n_pass++;
    do_access(1'b1, 1'b0, 3'b001, 32'h302, 32'h1234ABCD, 32'h0, 2, "sh_0x302");
    do_access(1'b1, 1'b1, 3'b010, 32'h40C, 32'hCAFEF00D, 32'h0, 1, "write_wins");
  endtask

  task automatic test_misaligned();
    do_misaligned(3'b010, 32'h101, "lw_0x101");
    do_misaligned(3'b001, 32'h301, "lh_0x301");
  endtask

  task automatic test_timeout();
    do_access(1'b0, 1'b0, 3'b010, 32'h500, 32'h0, 32'h11111111, 0, "timeout_read");
    n_total++;
    if (load_data !== 32'h0) $display("FAIL timeout_value: got %h expected 0", load_data); else n_pass++;
  endtask

  task automatic test_idle_ack();
    bus.ack = 1'b1; bus.rdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    bus.ack = 1'b0;
    #1;
    n_total++;
    if (bus.req !== 1'b0 || load_data !== exp_load)
      $display("FAIL idle_ack: req=%b load=%h expected 0/%h", bus.req, load_data, exp_load);
    else n_pass++;
  endtask

  task automatic test_reset_in_req();
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; read_address = 32'h400;
    @(posedge clk); #1;
    n_total++;
    if (bus.req !== 1'b1) $display("FAIL rst_req_start: req=%b expected 1", bus.req); else n_pass++;
    @(posedge clk); #1;
    bus.ack = 1'b1; bus.rdata = 32'h77777777; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.ack = 1'b0; mem_read = 1'b0;
    exp_load = 32'h0;
    #1;
    n_total++;
    if (bus.req !== 1'b0 || bus.adr !== 32'h0 || bus.sel !== 4'h0 || load_data !== 32'h0 || freeze !== 1'b0 || bus_err !== 1'b0)
      $display("FAIL rst_in_req: req=%b adr=%h sel=%b load=%h freeze=%b err=%b expected all 0",
               bus.req, bus.adr, bus.sel, load_data, freeze, bus_err);
    else n_pass++;
    do_access(1'b0, 1'b0, 3'b010, 32'h404, 32'h0, 32'h0BADF00D, 2, "lw_after_rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      bit          wr, both;
      logic [2:0]  f3;
      logic [31:0] a;
      int          sz;
      wr   = 1'($urandom % 2);
      both = ($urandom % 4) == 0;
      f3   = 3'($urandom % 8);
      sz   = size_of(f3);
      a    = $urandom;
      if (!wr && sz > 1 && ($urandom % 5) == 0) begin
        if ((a & (sz - 1)) == 0) a = a | 32'h1;
        do_misaligned(f3, a, "rand_mis");
      end else begin
        a = a & ~(32'(sz) - 32'd1);
        do_access(wr, both, f3, a, $urandom, $urandom, int'($urandom % 6), "rand");
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misaligned();
    test_timeout();
    test_idle_ack();
    test_reset_in_req();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
